// File: rtl/u409_cycle_decode_pkg.sv
// Shared types and address-space constants for the U409 CPU cycle decoder.
// Optional RTC decode is enabled by defining U409_RTC_DECODE_EN.
package u409_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ADDR_LO = 12;
    localparam int unsigned TT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ACKED  = 2'd2
    } state_t;

    // A[31:24] must be zero for every space except interrupt acknowledge
    localparam logic [7:0]        TOP_BYTE       = 8'h00;
    localparam logic [4:0]        ROM_SPACE      = 5'b11111;
    localparam logic [4:0]        ROM_OVL_SPACE  = 5'b00000;
    localparam logic [7:0]        CIA_SPACE      = 8'hBF;
    localparam logic [7:0]        RTC_SPACE      = 8'hDC;
    localparam logic [11:0]       CHIP_SPACE     = 12'hDFF;
    localparam logic [2:0]        CHIP_RAM_SPACE = 3'b000;
    localparam logic [ADDR_W-1:0] OVL_REG_ADDR   = 32'h00BF_E001;
    localparam logic [TT_W-1:0]   TT_IACK        = 2'b11;

    // One-hot address space produced by the matcher
    typedef struct packed {
        logic iack;
        logic rom;
        logic cia;
        logic rtc;
        logic chip;
    } space_t;

    // Registered decode outputs, all active high internally
    typedef struct packed {
        logic romen;
        logic rom_delay;
        logic cia;
        logic agnus;
        logic autovec;
        logic rtc;
    } dec_t;

endpackage

// File: rtl/u409_cycle_decode_if.sv
// CPU-side bus bundle for the U409 cycle decoder: the CPU/board drives through
// master, the decoder attaches as slave.
interface u409_cycle_decode_if;
    import u409_pkg::*;

    logic              CLK40;
    logic              TSn;
    logic              TACKn;
    logic [ADDR_W-1:0] A;
    logic [TT_W-1:0]   TT;
    logic              RnW;
    logic              OVL_DATA;
    logic              ROM_SLOWn;

    logic              ROMEN;
    logic              ROM_DELAY;
    logic              CIA_ENABLE;
    logic              AGNUS_SPACE;
    logic              AUTOVECTOR;
    logic              RTC_ENn;
    logic              OVL;

    modport master (
        output CLK40, TSn, TACKn, A, TT, RnW, OVL_DATA, ROM_SLOWn,
        input  ROMEN, ROM_DELAY, CIA_ENABLE, AGNUS_SPACE, AUTOVECTOR, RTC_ENn, OVL
    );

    modport slave (
        input  CLK40, TSn, TACKn, A, TT, RnW, OVL_DATA, ROM_SLOWn,
        output ROMEN, ROM_DELAY, CIA_ENABLE, AGNUS_SPACE, AUTOVECTOR, RTC_ENn, OVL
    );

endinterface

// File: rtl/u409_cycle_decode_addr_match.sv
// Combinational address/transfer-type matcher producing a one-hot space.
// The 0xDC RTC space is only decoded when U409_RTC_DECODE_EN is defined.
module u409_addr_match
    import u409_pkg::*;
(
    input  logic [ADDR_W-1:ADDR_LO] i_a,
    input  logic [TT_W-1:0]         i_tt,
    input  logic                    i_ovl,
    output space_t                  o_space_c
);

    logic w_low_space;
    assign w_low_space = (i_a[31:24] == TOP_BYTE);

    // Priority chain: iack, ROM, CIA, RTC, chip; anything else stays unresponsive
    always_comb begin
        o_space_c = '0;
        if (i_tt == TT_IACK) begin
            o_space_c.iack = 1'b1;
        end else if (w_low_space) begin
            if ((i_a[23:19] == ROM_SPACE) ||
                (i_ovl && (i_a[23:19] == ROM_OVL_SPACE))) begin
                o_space_c.rom = 1'b1;
            end else if (i_a[23:16] == CIA_SPACE) begin
                o_space_c.cia = 1'b1;
`ifdef U409_RTC_DECODE_EN
            end else if (i_a[23:16] == RTC_SPACE) begin
                o_space_c.rtc = 1'b1;
`endif
            end else if ((i_a[23:12] == CHIP_SPACE) ||
                         (!i_ovl && (i_a[23:21] == CHIP_RAM_SPACE))) begin
                o_space_c.chip = 1'b1;
            end
        end
    end

endmodule

// File: rtl/u409_cycle_decode.sv
// U409 CPU cycle decoder: captures a transfer start, registers the space decode
// until acknowledge, and tracks the ROM overlay bit (CIA-A PRA bit0).
// Build option: U409_RTC_DECODE_EN enables the RTC select (see u409_addr_match).
module u409_cycle_decode
    import u409_pkg::*;
(
    input  logic               CLK80,
    input  logic               RESETn,
    u409_cycle_decode_if.slave bus
);

    state_t r_state;
    state_t w_state_nxt;
    dec_t   r_dec;
    dec_t   w_dec_nxt;
    logic   r_ovl;
    logic   w_ovl_nxt;
    logic   r_wr_ovl;
    logic   w_wr_ovl_nxt;
    space_t w_space;
    logic   w_ts;
    logic   w_ovl_hit;

    // Decode always uses the overlay value held before the current cycle
    u409_addr_match u_addr_match (
        .i_a       (bus.A[ADDR_W-1:ADDR_LO]),
        .i_tt      (bus.TT),
        .i_ovl     (r_ovl),
        .o_space_c (w_space)
    );

    assign w_ts      = !bus.TSn && !bus.CLK40;
    assign w_ovl_hit = !bus.RnW && (bus.A == OVL_REG_ADDR);

    always_ff @(posedge CLK80) begin
        if (!RESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TSn is only looked at in IDLE; an early TACKn at capture belongs to the previous cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_ts)        w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!bus.TACKn)  w_state_nxt = ST_ACKED;
            ST_ACKED:  if (bus.TACKn)   w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_dec_nxt    = r_dec;
        w_ovl_nxt    = r_ovl;
        w_wr_ovl_nxt = r_wr_ovl;
        case (r_state)
            ST_IDLE: begin
                if (w_ts) begin
                    w_dec_nxt.romen     = w_space.rom;
                    w_dec_nxt.rom_delay = w_space.rom && !bus.ROM_SLOWn;
                    w_dec_nxt.cia       = w_space.cia;
                    w_dec_nxt.agnus     = w_space.chip;
                    w_dec_nxt.autovec   = w_space.iack;
                    w_dec_nxt.rtc       = w_space.rtc;
                    w_wr_ovl_nxt        = w_ovl_hit;
                end
            end
            ST_ACTIVE: begin
                if (!bus.TACKn) begin
                    w_dec_nxt    = '0;
                    w_wr_ovl_nxt = 1'b0;
                    if (r_wr_ovl) begin
                        w_ovl_nxt = bus.OVL_DATA;
                    end
                end
            end
            default: begin
                w_dec_nxt    = '0;
                w_wr_ovl_nxt = 1'b0;
            end
        endcase
    end

    // Reset wins over any pending overlay write
    always_ff @(posedge CLK80) begin
        if (!RESETn) begin
            r_dec    <= '0;
            r_ovl    <= 1'b1;
            r_wr_ovl <= 1'b0;
        end else begin
            r_dec    <= w_dec_nxt;
            r_ovl    <= w_ovl_nxt;
            r_wr_ovl <= w_wr_ovl_nxt;
        end
    end

    assign bus.ROMEN       = r_dec.romen;
    assign bus.ROM_DELAY   = r_dec.rom_delay;
    assign bus.CIA_ENABLE  = r_dec.cia;
    assign bus.AGNUS_SPACE = r_dec.agnus;
    assign bus.AUTOVECTOR  = r_dec.autovec;
    assign bus.RTC_ENn     = !r_dec.rtc;
    assign bus.OVL         = r_ovl;

endmodule

// File: tb/tb_u409_cycle_decode.sv
// Scoreboard bench for u409_cycle_decode: expected output vectors are queued
// when a cycle is driven and popped when the decoder's outputs are sampled.
module tb_u409_cycle_decode;
    import u409_pkg::*;

`ifdef U409_RTC_DECODE_EN
    localparam bit RTC_ON = 1'b1;
`else
    localparam bit RTC_ON = 1'b0;
`endif

    logic CLK80;
    logic RESETn;

    u409_cycle_decode_if bus ();

    u409_cycle_decode dut (
        .CLK80  (CLK80),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int unsigned n_checks;
    int unsigned n_fail;
    logic        model_ovl;
    logic [6:0]  sb_q[$];

    initial begin
        CLK80 = 1'b0;
        forever #6 CLK80 = ~CLK80;
    end

    // CLK40 changes on the falling CLK80 edge so it is stable at every rising edge
    always @(negedge CLK80) bus.CLK40 = ~bus.CLK40;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Vector layout: {ROMEN, ROM_DELAY, CIA_ENABLE, AGNUS_SPACE, AUTOVECTOR, RTC_ENn, OVL}
    function automatic logic [6:0] ref_out(input logic [31:0] a, input logic [1:0] tt,
                                           input logic ovl, input logic slown);
        logic        rom, cia, agnus, av, rtc;
        logic [23:0] lo;
        rom = 1'b0; cia = 1'b0; agnus = 1'b0; av = 1'b0; rtc = 1'b0;
        lo  = a[23:0];
        if (tt == 2'b11) begin
            av = 1'b1;
        end else if (a[31:24] == 8'h00) begin
            if (lo >= 24'hF80000 || (ovl && lo < 24'h080000))           rom = 1'b1;
            else if (lo >= 24'hBF0000 && lo <= 24'hBFFFFF)              cia = 1'b1;
            else if (RTC_ON && lo >= 24'hDC0000 && lo <= 24'hDCFFFF)    rtc = 1'b1;
            else if ((lo >= 24'hDFF000) && (lo <= 24'hDFFFFF))          agnus = 1'b1;
            else if (!ovl && lo < 24'h200000)                           agnus = 1'b1;
        end
        return {rom, rom && !slown, cia, agnus, av, !rtc, ovl};
    endfunction

    function automatic logic [6:0] idle_out(input logic ovl);
        return {5'b00000, 1'b1, ovl};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.ROMEN, bus.ROM_DELAY, bus.CIA_ENABLE, bus.AGNUS_SPACE,
                bus.AUTOVECTOR, bus.RTC_ENn, bus.OVL};
    endfunction

    task automatic sb_check(input string tag);
        logic [6:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %b with empty scoreboard, required a queued value", tag, obs());
        end else begin
            exp = sb_q.pop_front();
            chk(tag, 32'(obs()), 32'(exp));
        end
    endtask

    task automatic align_phase0(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(negedge CLK80);
            #1;
            if (bus.CLK40 == 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_align: got CLK40=1 throughout, required CLK40=0", tag);
        end
    endtask

    task automatic do_cycle(input string tag, input logic [31:0] a, input logic [1:0] tt,
                            input logic rnw, input logic ovl_data, input logic slown,
                            input int hold, input bit tack_at_cap, input bit second_ts,
                            input bit abort_reset);
        logic [6:0] exp_act;
        align_phase0(tag);
        bus.A         = a;
        bus.TT        = tt;
        bus.RnW       = rnw;
        bus.OVL_DATA  = ovl_data;
        bus.ROM_SLOWn = slown;
        bus.TSn       = 1'b0;
        if (tack_at_cap) bus.TACKn = 1'b0;
        exp_act = ref_out(a, tt, model_ovl, slown);
        sb_q.push_back(exp_act);
        @(posedge CLK80); #1;
        sb_check({tag, "_cap"});
        chk({tag, "_st_cap"}, 32'(dut.r_state), 32'(ST_ACTIVE));

        @(negedge CLK80);
        bus.TSn   = 1'b1;
        bus.TACKn = 1'b1;
        if (second_ts) begin
            bus.TSn = 1'b0;
            bus.A   = 32'h00BF0000;
            bus.RnW = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            sb_q.push_back(exp_act);
            @(posedge CLK80); #1;
            sb_check({tag, "_hold"});
        end
        chk({tag, "_st_hold"}, 32'(dut.r_state), 32'(ST_ACTIVE));

        @(negedge CLK80);
        bus.TSn = 1'b1;
        if (abort_reset) begin
            RESETn    = 1'b0;
            model_ovl = 1'b1;
            sb_q.push_back(idle_out(model_ovl));
            @(posedge CLK80); #1;
            sb_check({tag, "_rst"});
            chk({tag, "_st_rst"}, 32'(dut.r_state), 32'(ST_IDLE));
            @(negedge CLK80);
            RESETn = 1'b1;
        end else begin
            bus.TACKn = 1'b0;
            if (!rnw && a == 32'h00BFE001) model_ovl = ovl_data;
            sb_q.push_back(idle_out(model_ovl));
            @(posedge CLK80); #1;
            sb_check({tag, "_ack"});
            chk({tag, "_st_ack"}, 32'(dut.r_state), 32'(ST_ACKED));
            @(negedge CLK80);
            bus.TACKn = 1'b1;
            @(posedge CLK80); #1;
            chk({tag, "_st_idle"}, 32'(dut.r_state), 32'(ST_IDLE));
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        model_ovl     = 1'b1;
        RESETn        = 1'b0;
        bus.CLK40     = 1'b0;
        bus.TSn       = 1'b1;
        bus.TACKn     = 1'b1;
        bus.A         = '0;
        bus.TT        = '0;
        bus.RnW       = 1'b1;
        bus.OVL_DATA  = 1'b1;
        bus.ROM_SLOWn = 1'b1;

        repeat (3) @(posedge CLK80);
        #1;
        sb_q.push_back(idle_out(1'b1));
        sb_check("reset");
        chk("reset_st", 32'(dut.r_state), 32'(ST_IDLE));
        @(negedge CLK80);
        RESETn = 1'b1;

        //        tag              addr          tt     rnw   ovld  slown hold tack 2ts  rst
        do_cycle("rom_ovl",       32'h00000004, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("ovl_gap",       32'h00080000, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        do_cycle("tack_at_cap",   32'h00DFF000, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        do_cycle("cia_rd",        32'h00BFE001, 2'b00, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("ovl_wr",        32'h00BFE001, 2'b00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("chip_ram",      32'h00000004, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("iack",          32'hFFFFFFF1, 2'b11, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("hi_byte",       32'h01000004, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("rtc",           32'h00DC0000, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("slow_rom",      32'h00F80000, 2'b00, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        do_cycle("fast_rom",      32'h00FC0000, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_cycle("unresp_rst",    32'h00E00000, 2'b00, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        do_cycle("rom_after_rst", 32'h00000004, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/u409_cycle_decode.md
U409_CYCLE_DECODE -- requirements
Module: U409_CYCLE_DECODE

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: CLK80 is the clock; RESETn is the reset, sampled on the CLK80 rising edge.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK80  in  1  80 MHz system clock.
- RESETn  in  1  synchronous active-low reset.
- CLK40  in  1  CPU bus clock phase, sampled on CLK80.
- TSn  in  1  CPU transfer start.
- TACKn  in  1  transfer acknowledge; sensed only, never driven here.
- A  in  32  CPU address.
- TT  in  2  CPU transfer type.
- RnW  in  1  CPU read, high active.
- OVL_DATA  in  1  CPU data bit carrying CIA-A PRA bit0.
- ROM_SLOWn  in  1  board strap; low selects slow ROM.
- ROMEN  out  1  ROM cycle active.
- ROM_DELAY  out  1  slow-ROM request.
- CIA_ENABLE  out  1  CIA cycle active.
- AGNUS_SPACE  out  1  chip RAM/register cycle.
- AUTOVECTOR  out  1  interrupt acknowledge cycle.
- RTC_ENn  out  1  RTC select, active low.
- OVL  out  1  ROM overlay state.

Function
REQ-003 SHALL capture A, TT and RnW at the first CLK80 edge where TSn=0 and CLK40=0 (the capture edge).
REQ-004 SHALL register decode outputs at the capture edge, so they are valid at the next CLK80 edge (CLK40=1), where the TACK stage samples TSn.
REQ-005 SHALL decode, in priority order (A[31:24] must be 0x00 except for autovector):
- TT=2'b11 -> AUTOVECTOR.
- A[23:19]=5'b11111, or OVL=1 and A[23:19]=0 -> ROMEN.
- A[23:16]=0xBF -> CIA_ENABLE.
- A[23:16]=0xDC -> RTC_ENn=0.
- A[23:12]=0xDFF, or A[23:21]=0 with OVL=0 -> AGNUS_SPACE.
- anything else -> no output (unresponsive).
REQ-006 SHALL assert at most one of ROMEN, CIA_ENABLE, AGNUS_SPACE, AUTOVECTOR, !RTC_ENn at any time.
REQ-007 SHALL drive ROM_DELAY = ROMEN AND NOT ROM_SLOWn, with the same timing as ROMEN.
REQ-008 SHALL implement the state machine IDLE -> ACTIVE -> ACKED -> IDLE:
- IDLE -> ACTIVE on the capture edge.
- ACTIVE -> ACKED on the first edge with TACKn=0.
- ACKED -> IDLE on the first edge with TACKn=1.
REQ-009 SHALL hold decode outputs through ACTIVE and clear all of them on the ACTIVE->ACKED transition.
REQ-010 SHALL ignore TSn in ACTIVE and ACKED; no capture occurs until IDLE is re-entered.
REQ-011 SHALL, in ACTIVE with no decode (unresponsive), still wait for TACKn from the external timeout.
REQ-012 SHALL update OVL on the ACTIVE->ACKED edge when the captured cycle is a write (RnW=0) to A=0x00BFE001: OVL <= OVL_DATA.
REQ-013 SHALL handle a TACKn low at the same edge as capture by entering ACTIVE; the acknowledge belongs to the prior cycle.
REQ-014 SHALL decode using the OVL value held before the cycle, not the value being written.

Reset
REQ-015 SHALL, while RESETn=0, set state=IDLE, OVL=1, ROMEN=0, ROM_DELAY=0, CIA_ENABLE=0, AGNUS_SPACE=0, AUTOVECTOR=0, RTC_ENn=1.
REQ-016 SHALL, on reset mid-cycle, abandon the cycle with no OVL update.

Configuration
REQ-017 SHALL support macro U409_RTC_DECODE_EN:
- defined: the 0xDC space asserts RTC_ENn as in REQ-005.
- undefined: RTC_ENn is constant 1 and 0xDC is treated as unresponsive.

Structure
REQ-018 SHALL place the state enum, the address-space constants (ROM, CIA, RTC, CHIP, OVL_REG_ADDR) and the TT_IACK constant in package U409_PKG.
REQ-019 SHALL use one combinational sub-module, U409_ADDR_MATCH (A, TT, OVL -> one-hot space), instantiated once.

Verification
REQ-020 SHALL cover these directed scenarios:
- After reset, read A=0x00000004 -> ROMEN=1 one CLK80 after capture, OVL=1.
- Write 0x00BFE001 with OVL_DATA=0, then TACKn pulse -> OVL=0; a following read of 0x00000004 -> AGNUS_SPACE=1.
- TT=2'b11 at A=0xFFFFFFF1 -> AUTOVECTOR=1 only; cleared the edge after TACKn=0.
- Read 0x00DC0000 -> RTC_ENn=0 with macro defined, RTC_ENn=1 and no output with macro undefined.
- Read 0x00F80000 with ROM_SLOWn=0 -> ROMEN=1, ROM_DELAY=1; second TSn during ACTIVE is ignored.
- Read 0x00E00000 (unresponsive) -> no outputs, state stays ACTIVE until TACKn; RESETn=0 mid-cycle -> all REQ-015 values the next edge.
